// File: rtl/gray_pkg.sv
// gray_pkg
// Shared definitions for the up/down Gray counter.
//   mode_e    : range-end behaviour (WRAP rolls over, SAT holds).
//   bin2gray  : binary to Gray conversion on a MAX_W-bit container.
//   gray2bin  : Gray to binary conversion on a MAX_W-bit container.
// Both helpers work on zero-extended values, so callers of any width up to
// MAX_W pass a zero-extended operand and keep the low WIDTH bits of the result.
package gray_pkg;

   localparam int MAX_W = 32;

   typedef enum logic {
      WRAP = 1'b0,
      SAT  = 1'b1
   } mode_e;

   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero upper bits contribute nothing to the prefix XOR, so a narrow value
   // decodes correctly inside the wide container.
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b = '0;
      for (int i = MAX_W - 1; i >= 0; i--) begin
         b[i] = g[i] ^ ((i == MAX_W - 1) ? 1'b0 : b[i+1]);
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_counter_ud_if.sv
// gray_counter_ud_if
// Control and observation bundle of the up/down Gray counter.
//   en, up, load, load_gray : step request, direction, load request, load value
//   bin, gray, wrap         : registered counter state
//   gray_next, tc           : same-cycle combinational look-ahead
// There is no valid/ready handshake: en and load are per-cycle qualifiers
// that act on the next rising edge and are never back-pressured.
// master drives the controls (sequencer/bench); slave is the counter.
interface gray_counter_ud_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_gray;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] gray;
   logic [WIDTH-1:0] gray_next;
   logic             tc;
   logic             wrap;

   modport master (
      output en, up, load, load_gray,
      input  bin, gray, gray_next, tc, wrap
   );

   modport slave (
      input  en, up, load, load_gray,
      output bin, gray, gray_next, tc, wrap
   );
endinterface

// File: rtl/gray2bin_dec.sv
// gray2bin_dec
// Combinational Gray to binary decoder (prefix XOR from the MSB down).
//   gray : Gray-coded input, WIDTH bits
//   bin  : binary equivalent, WIDTH bits
module gray2bin_dec #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // Binary bit i is the XOR of all Gray bits at or above position i.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin[i] = ^(gray >> i);
   end

endmodule

// File: rtl/gray_counter_ud.sv
// gray_counter_ud
// Up/down counter that keeps a registered binary count and its registered
// Gray image in lock-step. Supports synchronous Gray-coded load, wrap or
// saturate at the range ends, and a one-cycle wrap pulse.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; restores RESET_VAL
//   bus   : gray_counter_ud_if slave (en, up, load, load_gray in;
//           bin, gray, wrap registered out; gray_next, tc combinational out)
// Update priority per edge: reset > load > en > hold.
module gray_counter_ud
   import gray_pkg::*;
#(
   parameter int          WIDTH     = 4,
   parameter int          SATURATE  = 0,
   parameter int unsigned RESET_VAL = 0
) (
   input logic               clk,
   input logic               reset,
   gray_counter_ud_if.slave  bus
);

   localparam mode_e            MODE     = (SATURATE != 0) ? SAT : WRAP;
   localparam logic [WIDTH-1:0] MAX_VAL  = '1;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

   logic [WIDTH-1:0] bin_r;
   logic [WIDTH-1:0] gray_r;
   logic             wrap_r;

   logic [WIDTH-1:0] load_bin;
   logic [WIDTH-1:0] step_bin;
   logic [MAX_W-1:0] step_gray_w;
   logic [WIDTH-1:0] bin_d;
   logic [WIDTH-1:0] gray_d;
   logic             wrap_d;
   logic             tc;

   gray2bin_dec #(
      .WIDTH (WIDTH)
   ) u_load_dec (
      .gray (bus.load_gray),
      .bin  (load_bin)
   );

   assign tc = bus.up ? (bin_r == MAX_VAL) : (bin_r == '0);

   // Modulo arithmetic already produces the wrapped value at the range
   // ends; saturation simply refuses to take the step when tc is high.
   assign step_bin    = bus.up ? (bin_r + ONE) : (bin_r - ONE);
   assign step_gray_w = bin2gray(MAX_W'(step_bin));

   always_comb begin
      bin_d  = bin_r;
      gray_d = gray_r;
      wrap_d = 1'b0;
      if (bus.load) begin
         bin_d  = load_bin;
         gray_d = bus.load_gray;
      end else if (bus.en) begin
         if (!tc || MODE == WRAP) begin
            bin_d  = step_bin;
            gray_d = step_gray_w[WIDTH-1:0];
            wrap_d = tc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bin_r  <= RST_BIN;
         gray_r <= RST_GRAY;
         wrap_r <= 1'b0;
      end else begin
         bin_r  <= bin_d;
         gray_r <= gray_d;
         wrap_r <= wrap_d;
      end
   end

   assign bus.bin       = bin_r;
   assign bus.gray      = gray_r;
   assign bus.wrap      = wrap_r;
   assign bus.gray_next = gray_d;
   assign bus.tc        = tc;

endmodule

// File: tb/tb_gray_counter_ud.sv
// tb_gray_counter_ud
// Bench for gray_counter_ud: a wrapping instance (RESET_VAL=0) and a
// saturating instance (RESET_VAL=3) share one clock.
module tb_gray_counter_ud;

   logic clk;
   logic rst_w;
   logic rst_s;
   int   n_tests;
   int   n_fail;

   gray_counter_ud_if #(.WIDTH(4)) if_w ();
   gray_counter_ud_if #(.WIDTH(4)) if_s ();

   gray_counter_ud #(.WIDTH(4), .SATURATE(0), .RESET_VAL(0)) dut_w (
      .clk   (clk),
      .reset (rst_w),
      .bus   (if_w)
   );

   gray_counter_ud #(.WIDTH(4), .SATURATE(1), .RESET_VAL(3)) dut_s (
      .clk   (clk),
      .reset (rst_s),
      .bus   (if_s)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference helpers ----------------
   function automatic int ref_gray(input int b);
      return b ^ (b >> 1);
   endfunction

   // Inverse found by search over the 16 codes rather than by decoding.
   function automatic int ref_bin_of_gray(input int g);
      int r;
      r = -1;
      for (int b = 0; b < 16; b++) if (ref_gray(b) == g) r = b;
      return r;
   endfunction

   function automatic void ref_step(input int b, input bit sat, input bit ld,
                                    input bit en, input bit up, input int lg,
                                    output int nb, output bit nw);
      nb = b;
      nw = 1'b0;
      if (ld) nb = ref_bin_of_gray(lg);
      else if (en && up) begin
         if (b == 15) begin
            if (!sat) begin nb = 0; nw = 1'b1; end
         end else nb = b + 1;
      end else if (en && !up) begin
         if (b == 0) begin
            if (!sat) begin nb = 15; nw = 1'b1; end
         end else nb = b - 1;
      end
   endfunction

   // ---------------- drivers ----------------
   task automatic drive_w(input bit en, input bit up, input bit ld, input logic [3:0] lg);
      if_w.en = en; if_w.up = up; if_w.load = ld; if_w.load_gray = lg;
   endtask

   task automatic drive_s(input bit en, input bit up, input bit ld, input logic [3:0] lg);
      if_s.en = en; if_s.up = up; if_s.load = ld; if_s.load_gray = lg;
   endtask

   // Advance one edge; outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_w = 1'b1; rst_s = 1'b1;
      drive_w(1'b1, 1'b1, 1'b0, 4'h0);
      drive_s(1'b1, 1'b1, 1'b0, 4'h0);
      tick(); tick();
      n_tests++; if (if_w.bin !== 4'd0)  begin n_fail++; $display("FAIL reset_bin_w got %h want 0", if_w.bin); end
      n_tests++; if (if_w.gray !== 4'd0) begin n_fail++; $display("FAIL reset_gray_w got %h want 0", if_w.gray); end
      n_tests++; if (if_w.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap_w got %b want 0", if_w.wrap); end
      n_tests++; if (if_s.bin !== 4'd3)  begin n_fail++; $display("FAIL reset_bin_s got %h want 3", if_s.bin); end
      n_tests++; if (if_s.gray !== 4'd2) begin n_fail++; $display("FAIL reset_gray_s got %h want 2", if_s.gray); end
      n_tests++; if (if_s.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap_s got %b want 0", if_s.wrap); end
      rst_w = 1'b0; rst_s = 1'b0;
      drive_w(1'b0, 1'b1, 1'b0, 4'h0);
      drive_s(1'b0, 1'b1, 1'b0, 4'h0);
   endtask

   task automatic test_count_up();
      logic [3:0] seq [17];
      logic [3:0] prev;
      seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
      rst_w = 1'b1; tick(); rst_w = 1'b0;
      prev = if_w.gray;
      n_tests++; if (prev !== seq[0]) begin n_fail++; $display("FAIL count_start got %h want %h", prev, seq[0]); end
      drive_w(1'b1, 1'b1, 1'b0, 4'h0);
      for (int k = 1; k <= 16; k++) begin
         tick();
         n_tests++; if (if_w.gray !== seq[k]) begin n_fail++; $display("FAIL count_gray step %0d got %h want %h", k, if_w.gray, seq[k]); end
         n_tests++; if (if_w.wrap !== (k == 16)) begin n_fail++; $display("FAIL count_wrap step %0d got %b want %b", k, if_w.wrap, (k == 16)); end
         n_tests++; if ($countones(prev ^ if_w.gray) != 1) begin n_fail++; $display("FAIL count_onebit step %0d prev %h now %h", k, prev, if_w.gray); end
         prev = if_w.gray;
      end
      drive_w(1'b0, 1'b1, 1'b0, 4'h0);
      tick();
      n_tests++; if (if_w.wrap !== 1'b0) begin n_fail++; $display("FAIL count_wrap_drop got %b want 0", if_w.wrap); end
   endtask

   task automatic test_load();
      drive_w(1'b0, 1'b1, 1'b1, 4'hC);
      #2;
      n_tests++; if (if_w.gray_next !== 4'hC) begin n_fail++; $display("FAIL load_gray_next got %h want C", if_w.gray_next); end
      tick();
      n_tests++; if (if_w.bin !== 4'd8)  begin n_fail++; $display("FAIL load_bin got %h want 8", if_w.bin); end
      n_tests++; if (if_w.gray !== 4'hC) begin n_fail++; $display("FAIL load_gray got %h want C", if_w.gray); end
      drive_w(1'b1, 1'b0, 1'b0, 4'h0);
      tick();
      n_tests++; if (if_w.bin !== 4'd7)  begin n_fail++; $display("FAIL load_dec_bin got %h want 7", if_w.bin); end
      n_tests++; if (if_w.gray !== 4'h4) begin n_fail++; $display("FAIL load_dec_gray got %h want 4", if_w.gray); end
      drive_w(1'b0, 1'b0, 1'b0, 4'h0);
   endtask

   task automatic test_load_priority();
      drive_w(1'b1, 1'b1, 1'b1, 4'h6);
      tick();
      n_tests++; if (if_w.bin !== 4'd4)  begin n_fail++; $display("FAIL prio_bin got %h want 4", if_w.bin); end
      n_tests++; if (if_w.gray !== 4'h6) begin n_fail++; $display("FAIL prio_gray got %h want 6", if_w.gray); end
      n_tests++; if (if_w.wrap !== 1'b0) begin n_fail++; $display("FAIL prio_wrap got %b want 0", if_w.wrap); end
      drive_w(1'b0, 1'b0, 1'b0, 4'h0);
   endtask

   task automatic test_wrap_down();
      drive_w(1'b0, 1'b0, 1'b1, 4'h0);
      tick();
      drive_w(1'b1, 1'b0, 1'b0, 4'h0);
      #2;
      n_tests++; if (if_w.tc !== 1'b1) begin n_fail++; $display("FAIL down_tc got %b want 1", if_w.tc); end
      n_tests++; if (if_w.gray_next !== 4'h8) begin n_fail++; $display("FAIL down_gray_next got %h want 8", if_w.gray_next); end
      tick();
      n_tests++; if (if_w.bin !== 4'hF)  begin n_fail++; $display("FAIL down_bin got %h want F", if_w.bin); end
      n_tests++; if (if_w.wrap !== 1'b1) begin n_fail++; $display("FAIL down_wrap got %b want 1", if_w.wrap); end
      drive_w(1'b0, 1'b0, 1'b0, 4'h0);
   endtask

   task automatic test_saturate();
      rst_s = 1'b1; tick(); rst_s = 1'b0;
      drive_s(1'b1, 1'b1, 1'b0, 4'h0);
      for (int k = 0; k < 12; k++) tick();
      n_tests++; if (if_s.bin !== 4'hF)  begin n_fail++; $display("FAIL sat_reach_bin got %h want F", if_s.bin); end
      n_tests++; if (if_s.gray !== 4'h8) begin n_fail++; $display("FAIL sat_reach_gray got %h want 8", if_s.gray); end
      for (int k = 0; k < 3; k++) begin
         #2;
         n_tests++; if (if_s.tc !== 1'b1) begin n_fail++; $display("FAIL sat_tc %0d got %b want 1", k, if_s.tc); end
         tick();
         n_tests++; if (if_s.bin !== 4'hF)  begin n_fail++; $display("FAIL sat_hold_bin %0d got %h want F", k, if_s.bin); end
         n_tests++; if (if_s.wrap !== 1'b0) begin n_fail++; $display("FAIL sat_wrap %0d got %b want 0", k, if_s.wrap); end
      end
      drive_s(1'b1, 1'b0, 1'b0, 4'h0);
      tick();
      n_tests++; if (if_s.bin !== 4'hE)  begin n_fail++; $display("FAIL sat_down_bin got %h want E", if_s.bin); end
      n_tests++; if (if_s.gray !== 4'h9) begin n_fail++; $display("FAIL sat_down_gray got %h want 9", if_s.gray); end
      drive_s(1'b0, 1'b0, 1'b0, 4'h0);
   endtask

   task automatic test_reset_midcount();
      drive_s(1'b0, 1'b0, 1'b1, 4'hD);
      tick();
      n_tests++; if (if_s.bin !== 4'd9) begin n_fail++; $display("FAIL midrst_pre_bin got %h want 9", if_s.bin); end
      drive_s(1'b1, 1'b1, 1'b1, 4'h5);
      rst_s = 1'b1;
      tick();
      rst_s = 1'b0;
      n_tests++; if (if_s.bin !== 4'd3)  begin n_fail++; $display("FAIL midrst_bin got %h want 3", if_s.bin); end
      n_tests++; if (if_s.gray !== 4'd2) begin n_fail++; $display("FAIL midrst_gray got %h want 2", if_s.gray); end
      n_tests++; if (if_s.wrap !== 1'b0) begin n_fail++; $display("FAIL midrst_wrap got %b want 0", if_s.wrap); end
      drive_s(1'b0, 1'b0, 1'b0, 4'h0);
   endtask

   task automatic test_random();
      int  mb_w, mb_s, nb;
      bit  nw, mw_w, mw_s;
      bit  en, up, ld, rst;
      int  lg;
      logic [3:0] gn_w, gn_s;
      rst_w = 1'b1; rst_s = 1'b1;
      drive_w(1'b0, 1'b0, 1'b0, 4'h0);
      drive_s(1'b0, 1'b0, 1'b0, 4'h0);
      tick();
      rst_w = 1'b0; rst_s = 1'b0;
      mb_w = 0; mw_w = 1'b0;
      mb_s = 3; mw_s = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         ld  = ($urandom_range(0, 9) == 0);
         en  = ($urandom_range(0, 3) != 0);
         up  = $urandom_range(0, 1);
         lg  = $urandom_range(0, 15);
         rst_w = rst; rst_s = rst;
         drive_w(en, up, ld, 4'(lg));
         drive_s(en, up, ld, 4'(lg));
         #2;
         n_tests++; if (if_w.tc !== (up ? (mb_w == 15) : (mb_w == 0))) begin n_fail++; $display("FAIL rnd_tc_w cyc %0d got %b bin_model %0d up %b", c, if_w.tc, mb_w, up); end
         n_tests++; if (if_s.tc !== (up ? (mb_s == 15) : (mb_s == 0))) begin n_fail++; $display("FAIL rnd_tc_s cyc %0d got %b bin_model %0d up %b", c, if_s.tc, mb_s, up); end
         gn_w = if_w.gray_next;
         gn_s = if_s.gray_next;
         if (rst) begin
            mb_w = 0; mw_w = 1'b0;
            mb_s = 3; mw_s = 1'b0;
         end else begin
            ref_step(mb_w, 1'b0, ld, en, up, lg, nb, nw); mb_w = nb; mw_w = nw;
            ref_step(mb_s, 1'b1, ld, en, up, lg, nb, nw); mb_s = nb; mw_s = nw;
         end
         tick();
         n_tests++; if (if_w.bin !== 4'(mb_w)) begin n_fail++; $display("FAIL rnd_bin_w cyc %0d got %h want %h", c, if_w.bin, 4'(mb_w)); end
         n_tests++; if (if_w.gray !== 4'(ref_gray(mb_w))) begin n_fail++; $display("FAIL rnd_gray_w cyc %0d got %h want %h", c, if_w.gray, 4'(ref_gray(mb_w))); end
         n_tests++; if (if_w.wrap !== mw_w) begin n_fail++; $display("FAIL rnd_wrap_w cyc %0d got %b want %b", c, if_w.wrap, mw_w); end
         n_tests++; if (if_s.bin !== 4'(mb_s)) begin n_fail++; $display("FAIL rnd_bin_s cyc %0d got %h want %h", c, if_s.bin, 4'(mb_s)); end
         n_tests++; if (if_s.gray !== 4'(ref_gray(mb_s))) begin n_fail++; $display("FAIL rnd_gray_s cyc %0d got %h want %h", c, if_s.gray, 4'(ref_gray(mb_s))); end
         n_tests++; if (if_s.wrap !== mw_s) begin n_fail++; $display("FAIL rnd_wrap_s cyc %0d got %b want %b", c, if_s.wrap, mw_s); end
         n_tests++; if (if_w.gray !== (if_w.bin ^ (if_w.bin >> 1))) begin n_fail++; $display("FAIL rnd_invariant_w cyc %0d bin %h gray %h", c, if_w.bin, if_w.gray); end
         if (!rst) begin
            n_tests++; if (gn_w !== if_w.gray) begin n_fail++; $display("FAIL rnd_gray_next_w cyc %0d got %h then gray %h", c, gn_w, if_w.gray); end
            n_tests++; if (gn_s !== if_s.gray) begin n_fail++; $display("FAIL rnd_gray_next_s cyc %0d got %h then gray %h", c, gn_s, if_s.gray); end
         end
      end
      rst_w = 1'b0; rst_s = 1'b0;
      drive_w(1'b0, 1'b0, 1'b0, 4'h0);
      drive_s(1'b0, 1'b0, 1'b0, 4'h0);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_w   = 1'b1;
      rst_s   = 1'b1;
      drive_w(1'b0, 1'b0, 1'b0, 4'h0);
      drive_s(1'b0, 1'b0, 1'b0, 4'h0);
      tick();
      test_reset();
      test_count_up();
      test_load();
      test_load_priority();
      test_wrap_down();
      test_saturate();
      test_reset_midcount();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
